fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the pipelined core: owns the PC register, the instruction-memory request handshake, a one-entry hold buffer and the IF/ID pipeline register. It is the consumer of the hazard unit's control outputs (pc_WEN, the IF/ID stall, ifid_FLUSH) and of BranchTaken. It converts them into correctly ordered, squash-safe fetches, including discarding a wrong-path word that is already in flight.

## Interface
Clocking: one clock; reset is synchronous and active-high.

Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded at reset
- PC_STEP, 4, byte increment per sequential fetch

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  synchronous reset, active-high
- pc_WEN  in  1  hazard unit permits starting a new fetch
- ifid_stall  in  1  IF/ID hold (IF/ID field of pipe_stall_t)
- ifid_FLUSH  in  1  squash IF/ID contents this cycle
- BranchTaken  in  1  redirect request from EX/MEM
- branch_target  in  32  redirect PC (word_t)
- halt  in  1  halt retired; stop fetching
- imemREN  out  1  instruction read request
- imemaddr  out  32  request address
- ihit  in  1  request completes this cycle
- imemload  in  32  instruction word, valid with ihit
- ifid_valid  out  1  IF/ID holds a real instruction
- ifid_instr  out  32  instruction (32'h0 = nop when invalid)
- ifid_pc  out  32  PC of instruction
- ifid_npc  out  32  ifid_pc + PC_STEP

## Operation
- State FSM fetch_state_t: RUN, DRAIN, HALT. Reset → RUN.
- Request protocol: imemaddr is latched by memory at request start and must not change until ihit.
  - req_active flag: set when imemREN=1 and ihit=0; cleared on ihit.
  - imemREN = !RST && (req_active || (state==RUN && pc_WEN && !hold_valid)).
  - imemaddr = pc. pc is never modified while req_active, except in the cycle of ihit.
- RUN, ihit, no BranchTaken: the word is accepted and pc <= pc + PC_STEP (mod 2^32).
  - If IF/ID loads this cycle (see below), the word goes to IF/ID.
  - Otherwise it goes to the hold buffer: hold_valid=1, hold_instr, hold_pc.
- RUN, BranchTaken:
  - If ihit or !req_active: the word (if any) is discarded, pc <= branch_target, stay RUN.
  - If req_active && !ihit: redirect <= branch_target, go to DRAIN.
  - In all cases hold_valid <= 0.
- DRAIN: imemREN held high by req_active. On ihit the word is discarded, pc <= redirect, go to RUN. A further BranchTaken in DRAIN overwrites redirect.
- halt (any state):
  - If !req_active, or ihit this cycle: go to HALT.
  - Otherwise go to DRAIN-to-HALT, i.e. HALT with req_active still set: the outstanding word is discarded on ihit and no new request is issued.
  - HALT exits only on RST.
- IF/ID update, in priority order:
  - RST: all fields 0.
  - ifid_FLUSH: valid=0, instr=0. Flush overrides stall.
  - ifid_stall: hold the current value.
  - hold_valid: load from the hold buffer, clear hold_valid.
  - Accepted word this cycle: load it.
  - Otherwise: bubble (valid=0, instr=0, pc/npc=0).

## Timing
- Reset values: pc=PC_INIT, state RUN, req_active=0, hold_valid=0, IF/ID all 0, imemREN=0 during RST.
- First request is at PC_INIT in the cycle after RST deasserts, provided pc_WEN=1.
- Latency: ihit on cycle N → instruction visible at IF/ID outputs in cycle N+1 (no stall).
- Hold-buffer path: word captured at cycle N under stall → released in the first cycle with ifid_stall=0, visible the cycle after.
- Simultaneous cases:
  - BranchTaken + ihit: redirect wins and the word is dropped.
  - ifid_FLUSH + hold_valid with no stall: hold is consumed and lost only if BranchTaken also asserts; otherwise hold is retained.
  - halt + BranchTaken: halt wins.
- RST mid-request: state cleared. A late ihit after reset with req_active=0 and imemREN=0 is ignored.

## Structure
- In aww_types_pkg: fetch_state_t enum {RUN, DRAIN, HALT}, and ifid_t struct {valid, instr, pc, npc}.
- word_t and the nop constant come from cpu_types_pkg.
- Add fetch_unit_if, a modport pair mirroring the hazard-unit interface style.
- Single module; no sub-module needed (the hold buffer is a few registers).

## Test plan
- Reset, pc_WEN=1, ihit every cycle: imemaddr sequence 0,4,8,… and IF/ID shows pc 0,4 with valid=1 one cycle after each ihit.
- ihit with instr 32'h2001_0005 at pc 0x8 while ifid_stall=1 for 3 cycles: imemREN drops, hold retained; after release IF/ID shows pc 0x8, next fetch at 0xC.
- BranchTaken (target 0x40) while a request at 0x10 is outstanding, ihit 2 cycles later: word discarded, next imemaddr=0x40, IF/ID never shows pc 0x10.
- BranchTaken + ihit in the same cycle: word discarded, next request at target, IF/ID gets a bubble.
- halt with a request outstanding: imemREN stays high until ihit, then stays 0 forever; IF/ID valid goes 0.
- RST asserted during DRAIN: next cycle pc=PC_INIT, state RUN, hold_valid=0, imemREN=0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction-fetch stage: machine word, fetch FSM states
// and the IF/ID pipeline register layout.
package fetch_unit_pkg;

  typedef logic [31:0] word_t;

  localparam word_t NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALT
  } fetch_state_t;

  typedef struct packed {
    logic  valid;
    word_t instr;
    word_t pc;
    word_t npc;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{valid: 1'b0, instr: NOP, pc: '0, npc: '0};

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's control, instruction-memory and IF/ID signals,
// with one view for the fetch stage and one for the hazard/memory side.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic  pc_WEN;
  logic  ifid_stall;
  logic  ifid_FLUSH;
  logic  BranchTaken;
  word_t branch_target;
  logic  halt;
  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  ifid_valid;
  word_t ifid_instr;
  word_t ifid_pc;
  word_t ifid_npc;

  modport fetch (
    input  pc_WEN, ifid_stall, ifid_FLUSH, BranchTaken, branch_target, halt,
    input  ihit, imemload,
    output imemREN, imemaddr,
    output ifid_valid, ifid_instr, ifid_pc, ifid_npc
  );

  modport ctrl (
    output pc_WEN, ifid_stall, ifid_FLUSH, BranchTaken, branch_target, halt,
    output ihit, imemload,
    input  imemREN, imemaddr,
    input  ifid_valid, ifid_instr, ifid_pc, ifid_npc
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, imem request handshake, one-entry hold
// buffer and IF/ID register, with squash-safe redirect and halt handling.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter int unsigned PC_STEP = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        pc_WEN,
  input  logic        ifid_stall,
  input  logic        ifid_FLUSH,
  input  logic        BranchTaken,
  input  logic [31:0] branch_target,
  input  logic        halt,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_npc
);

  localparam word_t STEP = word_t'(PC_STEP);

  fetch_state_t state, state_next;
  word_t        pc, pc_next;
  word_t        redirect, redirect_next;
  logic         req_active, req_active_next;
  logic         hold_valid, hold_valid_next;
  word_t        hold_instr, hold_instr_next;
  word_t        hold_pc, hold_pc_next;
  ifid_t        ifid, ifid_next;

  logic hit;             // request completes this cycle
  logic in_flight;       // a request will still be outstanding after this edge
  logic accept;          // completed word is on the correct path and kept
  logic branch_eff;      // redirect actually applies (halt has priority)
  logic ifid_takes_word; // IF/ID is free to take the word arriving now

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latches).
    imemREN         = !RST && (req_active || (state == RUN && pc_WEN && !hold_valid));
    imemaddr        = pc;
    hit             = imemREN && ihit;
    in_flight       = imemREN && !ihit;
    branch_eff      = BranchTaken && !halt && (state != HALT);
    accept          = hit && (state == RUN) && !BranchTaken && !halt;
    ifid_takes_word = !ifid_FLUSH && !ifid_stall && !hold_valid;

    state_next      = state;
    pc_next         = pc;
    redirect_next   = redirect;
    req_active_next = in_flight;
    hold_valid_next = hold_valid;
    hold_instr_next = hold_instr;
    hold_pc_next    = hold_pc;
    ifid_next       = ifid;

    // Halt wins over everything; an outstanding word drains in HALT with req_active set.
    if (halt) begin
      state_next = HALT;
    end else begin
      case (state)
        RUN: begin
          if (BranchTaken) begin
            // The memory latched pc; it cannot move until the in-flight word returns.
            if (in_flight) begin
              redirect_next = branch_target;
              state_next    = DRAIN;
            end else begin
              pc_next = branch_target;
            end
          end else if (accept) begin
            pc_next = pc + STEP;
          end
        end
        DRAIN: begin
          if (hit) begin
            pc_next    = BranchTaken ? branch_target : redirect;
            state_next = RUN;
          end else if (BranchTaken) begin
            redirect_next = branch_target;
          end
        end
        HALT: ;
        default: state_next = RUN;
      endcase
    end

    if (branch_eff) begin
      hold_valid_next = 1'b0;
    end else if (accept && !ifid_takes_word) begin
      hold_valid_next = 1'b1;
      hold_instr_next = imemload;
      hold_pc_next    = pc;
    end else if (hold_valid && !ifid_FLUSH && !ifid_stall) begin
      hold_valid_next = 1'b0;
    end

    if (ifid_FLUSH) begin
      ifid_next = IFID_BUBBLE;
    end else if (ifid_stall) begin
      ifid_next = ifid;
    end else if (hold_valid) begin
      ifid_next = '{valid: 1'b1, instr: hold_instr, pc: hold_pc, npc: hold_pc + STEP};
    end else if (accept) begin
      ifid_next = '{valid: 1'b1, instr: imemload, pc: pc, npc: pc + STEP};
    end else begin
      ifid_next = IFID_BUBBLE;
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (RST) begin
      state      <= RUN;
      pc         <= PC_INIT;
      redirect   <= '0;
      req_active <= 1'b0;
      hold_valid <= 1'b0;
      hold_instr <= '0;
      hold_pc    <= '0;
      ifid       <= IFID_BUBBLE;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      redirect   <= redirect_next;
      req_active <= req_active_next;
      hold_valid <= hold_valid_next;
      hold_instr <= hold_instr_next;
      hold_pc    <= hold_pc_next;
      ifid       <= ifid_next;
    end
  end

  assign ifid_valid = ifid.valid;
  assign ifid_instr = ifid.instr;
  assign ifid_pc    = ifid.pc;
  assign ifid_npc   = ifid.npc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// against a queue-based reference model and a variable-latency memory.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam word_t       PC_INIT = 32'h0000_0000;
  localparam int unsigned STEP    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if fif();

  fetch_unit #(.PC_INIT(PC_INIT), .PC_STEP(STEP)) dut (
    .CLK          (clk),
    .RST          (rst),
    .pc_WEN       (fif.pc_WEN),
    .ifid_stall   (fif.ifid_stall),
    .ifid_FLUSH   (fif.ifid_FLUSH),
    .BranchTaken  (fif.BranchTaken),
    .branch_target(fif.branch_target),
    .halt         (fif.halt),
    .imemREN      (fif.imemREN),
    .imemaddr     (fif.imemaddr),
    .ihit         (fif.ihit),
    .imemload     (fif.imemload),
    .ifid_valid   (fif.ifid_valid),
    .ifid_instr   (fif.ifid_instr),
    .ifid_pc      (fif.ifid_pc),
    .ifid_npc     (fif.ifid_npc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Instruction memory contents as a pure function of address.
  function automatic word_t mem_word(input word_t a);
    if (a == 32'h8) return 32'h2001_0005;
    return (a * 32'h9E37_79B9) ^ 32'h1357_0001;
  endfunction

  // Reference model: program order as a PC, a pending-redirect flag, a halted
  // flag, and the hold buffer as a FIFO of fetched-but-undelivered words.
  typedef struct {
    word_t instr;
    word_t pc;
  } held_t;

  held_t hold_q[$];
  bit    m_halted, m_pend, m_busy;
  word_t m_pc, m_redir;
  bit    e_valid;
  word_t e_instr, e_pc, e_npc;

  // Memory responder state.
  bit    mem_busy = 1'b0;
  word_t mem_addr = '0;
  int    mem_cnt  = 0;
  int    mem_lat  = 0;

  logic  obs_ren;
  word_t obs_addr;

  task automatic model_reset();
    hold_q.delete();
    m_halted = 1'b0;
    m_pend   = 1'b0;
    m_busy   = 1'b0;
    m_pc     = PC_INIT;
    m_redir  = '0;
    e_valid  = 1'b0;
    e_instr  = '0;
    e_pc     = '0;
    e_npc    = '0;
  endtask

  task automatic model_update(input bit r, input bit stall, input bit flush, input bit br,
                              input word_t tgt, input bit hlt, input bit ih, input bit ren_e);
    bit    hit, take, took;
    word_t word;
    held_t h;
    if (r) begin
      model_reset();
      return;
    end
    hit  = ih && ren_e;
    take = hit && !m_halted && !m_pend && !br && !hlt;
    word = mem_word(m_pc);
    took = 1'b0;

    if (flush) begin
      e_valid = 0; e_instr = '0; e_pc = '0; e_npc = '0;
    end else if (stall) begin
      // IF/ID keeps its contents
    end else if (hold_q.size() > 0) begin
      h = hold_q.pop_front();
      e_valid = 1; e_instr = h.instr; e_pc = h.pc; e_npc = h.pc + STEP;
    end else if (take) begin
      e_valid = 1; e_instr = word; e_pc = m_pc; e_npc = m_pc + STEP;
      took = 1'b1;
    end else begin
      e_valid = 0; e_instr = '0; e_pc = '0; e_npc = '0;
    end

    if (br && !hlt && !m_halted) hold_q.delete();
    else if (take && !took) hold_q.push_back('{instr: word, pc: m_pc});

    if (hlt) begin
      m_halted = 1'b1;
    end else if (!m_halted) begin
      if (br) begin
        if (ren_e && !ih) begin
          m_pend  = 1'b1;
          m_redir = tgt;
        end else begin
          m_pc   = tgt;
          m_pend = 1'b0;
        end
      end else if (m_pend) begin
        if (hit) begin
          m_pc   = m_redir;
          m_pend = 1'b0;
        end
      end else if (take) begin
        m_pc = m_pc + STEP;
      end
    end
    m_busy = ren_e && !ih;
  endtask

  // One clock cycle: check registered outputs, drive inputs, check the request,
  // answer from memory, then advance the model on the rising edge.
  task automatic step(input bit r, input bit wen, input bit stall, input bit flush,
                      input bit br, input word_t tgt, input bit hlt, input bit force_hit);
    bit exp_ren, hit_i;
    check("ifid_valid", fif.ifid_valid, e_valid);
    check("ifid_instr", fif.ifid_instr, e_instr);
    check("ifid_pc",    fif.ifid_pc,    e_pc);
    check("ifid_npc",   fif.ifid_npc,   e_npc);

    rst               = r;
    fif.pc_WEN        = wen;
    fif.ifid_stall    = stall;
    fif.ifid_FLUSH    = flush;
    fif.BranchTaken   = br;
    fif.branch_target = tgt;
    fif.halt          = hlt;
    fif.ihit          = 1'b0;
    #1;
    obs_ren  = fif.imemREN;
    obs_addr = fif.imemaddr;
    exp_ren  = !r && (m_busy || (!m_halted && !m_pend && wen && hold_q.size() == 0));
    check("imemREN", obs_ren, exp_ren);
    if (obs_ren) begin
      check("imemaddr", obs_addr, m_pc);
      if (mem_busy) check("addr_stable", obs_addr, mem_addr);
      else begin
        mem_addr = obs_addr;
        mem_cnt  = mem_lat;
      end
    end
    hit_i        = (obs_ren && mem_cnt == 0) || force_hit;
    fif.ihit     = hit_i;
    fif.imemload = hit_i ? mem_word(mem_addr) : word_t'($urandom());

    @(posedge clk);
    model_update(r, stall, flush, br, tgt, hlt, hit_i, exp_ren);
    if (r) mem_busy = 1'b0;
    else if (obs_ren) begin
      if (hit_i) mem_busy = 1'b0;
      else begin
        mem_busy = 1'b1;
        mem_cnt--;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    mem_lat = 0;
    step(1, 0, 0, 0, 0, '0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    fif.pc_WEN = 0; fif.ifid_stall = 0; fif.ifid_FLUSH = 0; fif.BranchTaken = 0;
    fif.branch_target = '0; fif.halt = 0; fif.ihit = 0; fif.imemload = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();

    // Sequential fetch with single-cycle memory.
    do_reset();
    check("rst_ifid_valid", fif.ifid_valid, 0);
    check("rst_ifid_pc", fif.ifid_pc, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, 0, 0, '0, 0, 0);
      check("seq_addr", obs_addr, 32'(i * 4));
    end
    check("seq_last_pc", fif.ifid_pc, 32'h14);
    check("seq_last_valid", fif.ifid_valid, 1);

    // Word at 0x8 arrives under a 3-cycle stall and waits in the hold buffer.
    do_reset();
    step(0, 1, 0, 0, 0, '0, 0, 0);
    step(0, 1, 0, 0, 0, '0, 0, 0);
    step(0, 1, 1, 0, 0, '0, 0, 0);
    check("hold_addr", obs_addr, 32'h8);
    step(0, 1, 1, 0, 0, '0, 0, 0);
    check("hold_ren_off1", obs_ren, 0);
    step(0, 1, 1, 0, 0, '0, 0, 0);
    check("hold_ren_off2", obs_ren, 0);
    step(0, 1, 0, 0, 0, '0, 0, 0);
    check("hold_release_ren", obs_ren, 0);
    check("hold_ifid_pc", fif.ifid_pc, 32'h8);
    check("hold_ifid_instr", fif.ifid_instr, 32'h2001_0005);
    step(0, 1, 0, 0, 0, '0, 0, 0);
    check("hold_next_addr", obs_addr, 32'hC);

    // Redirect while the request at 0x10 is outstanding.
    do_reset();
    repeat (4) step(0, 1, 0, 0, 0, '0, 0, 0);
    mem_lat = 2;
    step(0, 1, 0, 0, 0, '0, 0, 0);
    check("drain_req_addr", obs_addr, 32'h10);
    step(0, 1, 0, 0, 1, 32'h40, 0, 0);
    check("drain_addr_hold1", obs_addr, 32'h10);
    step(0, 1, 0, 0, 0, '0, 0, 0);
    check("drain_addr_hold2", obs_addr, 32'h10);
    mem_lat = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0, '0, 0, 0);
      if (i == 0) check("drain_target_addr", obs_addr, 32'h40);
      check("drain_no_0x10", fif.ifid_pc == 32'h10, 0);
    end

    // Redirect in the same cycle as ihit.
    do_reset();
    step(0, 1, 0, 0, 0, '0, 0, 0);
    step(0, 1, 0, 0, 1, 32'h80, 0, 0);
    check("br_hit_bubble", fif.ifid_valid, 0);
    step(0, 1, 0, 0, 0, '0, 0, 0);
    check("br_hit_addr", obs_addr, 32'h80);

    // Halt with a request outstanding.
    do_reset();
    step(0, 1, 0, 0, 0, '0, 0, 0);
    mem_lat = 2;
    step(0, 1, 0, 0, 0, '0, 0, 0);
    step(0, 1, 0, 0, 0, '0, 1, 0);
    check("halt_ren_drain", obs_ren, 1);
    step(0, 1, 0, 0, 0, '0, 0, 0);
    check("halt_ren_hit", obs_ren, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0, 1, 32'h200, 0, 0);
      check("halt_ren_off", obs_ren, 0);
      check("halt_ifid_valid", fif.ifid_valid, 0);
    end

    // Reset during DRAIN, then a stray ihit.
    do_reset();
    step(0, 1, 0, 0, 0, '0, 0, 0);
    mem_lat = 3;
    step(0, 1, 0, 0, 0, '0, 0, 0);
    step(0, 1, 0, 0, 1, 32'h100, 0, 0);
    step(1, 1, 0, 0, 0, '0, 0, 0);
    check("rst_drain_ren", obs_ren, 0);
    mem_lat = 0;
    step(0, 0, 0, 0, 0, '0, 0, 1);
    check("late_hit_ren", obs_ren, 0);
    check("late_hit_valid", fif.ifid_valid, 0);
    step(0, 1, 0, 0, 0, '0, 0, 0);
    check("rst_drain_addr", obs_addr, PC_INIT);
    check("rst_drain_ren_on", obs_ren, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      bit    r, wen, stall, flush, br, hlt, fh;
      word_t tgt;
      r     = ($urandom_range(0, 99) < (m_halted ? 10 : 1));
      wen   = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      br    = ($urandom_range(0, 7) == 0);
      hlt   = ($urandom_range(0, 249) == 0);
      fh    = ($urandom_range(0, 49) == 0);
      tgt   = word_t'($urandom_range(0, 255)) << 2;
      mem_lat = $urandom_range(0, 2);
      step(r, wen, stall, flush, br, tgt, hlt, fh);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
